// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit FIFO feeding a UART serializer.
//   PCLK/PRESET         : single rising-edge clock, synchronous active-high reset
//   wr_en/wr_data       : push a character into the FIFO (dropped when full)
//   divisor             : bit period = divisor+1 PCLK cycles, latched per frame
//   tx_en               : permits new frames to start
//   parity_en/parity_odd: optional parity bit, odd when parity_odd=1
//   stop2               : two stop bits when 1
//   UART_SOUT           : registered serial line, idles high
//   TXDRDYn             : low while a push will be accepted
//   level/empty/full    : registered FIFO occupancy and flags
//   busy                : serializer is in a non-IDLE state
//   overflow            : one-cycle pulse per rejected push
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DIV_W-1:0]              divisor,
  input  logic                          tx_en,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  output logic                          UART_SOUT,
  output logic                          TXDRDYn,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          empty,
  output logic                          full,
  output logic                          busy,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              push, pop;
  logic [LW-1:0]     level_n;

  // full is the registered flag, so a push is judged before any same-cycle pop
  assign push    = wr_en & ~full;
  assign level_n = level + LW'(push) - LW'(pop);
  assign TXDRDYn = full;

  always_ff @(posedge PCLK) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      level    <= level_n;
      empty    <= (level_n == '0);
      full     <= (level_n == LW'(FIFO_DEPTH));
      overflow <= wr_en & full;
    end
  end

  // ---------------- serializer ----------------
  state_t            state, state_n;
  logic [DIV_W-1:0]  cnt, cnt_n, div_l, div_n;
  logic [IW-1:0]     idx, idx_n;
  logic              sidx, sidx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_en_l, par_en_n, par_bit_l, par_bit_n, stop2_l, stop2_n;
  logic              sout_n;
  logic              cnt_last, stop_last, start;
  logic [DATA_W-1:0] head;

  assign head      = mem[rptr];
  assign cnt_last  = (cnt == div_l);
  assign stop_last = (state == S_STOP) && cnt_last && (sidx == stop2_l);
  // Starting in the last STOP cycle gives gap-free back-to-back frames
  assign start     = tx_en && !empty && ((state == S_IDLE) || stop_last);
  assign pop       = start;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + DIV_W'(1);
    idx_n     = idx;
    sidx_n    = sidx;
    shreg_n   = shreg;
    div_n     = div_l;
    par_en_n  = par_en_l;
    par_bit_n = par_bit_l;
    stop2_n   = stop2_l;
    sout_n    = UART_SOUT;
    case (state)
      S_IDLE: begin
        cnt_n  = '0;
        sout_n = 1'b1;
      end
      S_START: begin
        if (cnt_last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_DATA;
          sout_n  = shreg[0];
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (idx == IW'(DATA_W-1)) begin
            sidx_n = 1'b0;
            if (par_en_l) begin
              state_n = S_PARITY;
              sout_n  = par_bit_l;
            end else begin
              state_n = S_STOP;
              sout_n  = 1'b1;
            end
          end else begin
            idx_n   = idx + IW'(1);
            shreg_n = shreg >> 1;
            sout_n  = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (cnt_last) begin
          cnt_n   = '0;
          sidx_n  = 1'b0;
          state_n = S_STOP;
          sout_n  = 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (sidx == stop2_l) begin
            state_n = S_IDLE;
            sout_n  = 1'b1;
          end else begin
            sidx_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        sout_n  = 1'b1;
      end
    endcase
    // Frame launch overrides IDLE / end-of-STOP: latch head word and config
    if (start) begin
      state_n   = S_START;
      cnt_n     = '0;
      sout_n    = 1'b0;
      shreg_n   = head;
      div_n     = divisor;
      par_en_n  = parity_en;
      par_bit_n = (^head) ^ parity_odd;
      stop2_n   = stop2;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sidx      <= 1'b0;
      shreg     <= '0;
      div_l     <= '0;
      par_en_l  <= 1'b0;
      par_bit_l <= 1'b0;
      stop2_l   <= 1'b0;
      UART_SOUT <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sidx      <= sidx_n;
      shreg     <= shreg_n;
      div_l     <= div_n;
      par_en_l  <= par_en_n;
      par_bit_l <= par_bit_n;
      stop2_l   <= stop2_n;
      UART_SOUT <= sout_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a queue-based reference model of
// the FIFO and the expected serial waveform, checked every cycle, plus
// literal frame captures.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic        PCLK = 1'b0, PRESET = 1'b1, wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [15:0] divisor = 16'd3;
  logic        tx_en = 1'b0, parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic        UART_SOUT, TXDRDYn, empty, full, busy, overflow;
  logic [4:0]  level;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .wr_en(wr_en), .wr_data(wr_data),
    .divisor(divisor), .tx_en(tx_en), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .UART_SOUT(UART_SOUT),
    .TXDRDYn(TXDRDYn), .level(level), .empty(empty), .full(full),
    .busy(busy), .overflow(overflow));

  always #5 PCLK = ~PCLK;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  bit         wave[$];  // expected line level for each upcoming cycle
  bit         m_empty = 1'b1, m_full = 1'b0, m_ovf = 1'b0, chk_on = 1'b0;
  int         m_level = 0;
  bit         m_st, m_ovf_n;
  logic [7:0] m_d;
  int         m_per;

  task automatic add_bit(input bit b, input int per);
    for (int k = 0; k < per; k++) wave.push_back(b);
  endtask

  always @(posedge PCLK) begin
    if (PRESET) begin
      q.delete(); wave.delete();
      m_empty = 1'b1; m_full = 1'b0; m_ovf = 1'b0; m_level = 0;
    end else begin
      m_st    = tx_en && !m_empty && (wave.size() <= 1);
      m_ovf_n = wr_en && m_full;
      if (wave.size() > 0) void'(wave.pop_front());
      if (m_st) begin
        m_d   = q.pop_front();
        m_per = int'(divisor) + 1;
        add_bit(1'b0, m_per);
        for (int b = 0; b < 8; b++) add_bit(m_d[b], m_per);
        if (parity_en) add_bit((^m_d) ^ parity_odd, m_per);
        add_bit(1'b1, m_per);
        if (stop2) add_bit(1'b1, m_per);
      end
      if (wr_en && !m_full) q.push_back(wr_data);
      m_ovf   = m_ovf_n;
      m_level = q.size();
      m_empty = (q.size() == 0);
      m_full  = (q.size() == DEPTH);
    end
  end

  always @(negedge PCLK) begin
    if (chk_on) begin
      check("sout",     UART_SOUT, (wave.size() > 0) ? wave[0] : 1'b1);
      check("busy",     busy,      wave.size() > 0);
      check("level",    level,     m_level);
      check("empty",    empty,     m_empty);
      check("full",     full,      m_full);
      check("txdrdyn",  TXDRDYn,   m_full);
      check("overflow", overflow,  m_ovf);
    end
  end

  // ---------------- helpers ----------------
  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge PCLK);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || !empty) && w < 2000) begin @(negedge PCLK); w++; end
    if (busy || !empty) check("wait_idle timeout", 32'd1, 32'd0);
  endtask

  // samples the first cycle of each bit period once busy is seen
  task automatic capture(input int per, input int nbits, input int maxlen,
                         output logic [255:0] bits, output int len);
    int w = 0;
    bits = '0; len = 0;
    while (!busy && w < 50) begin @(negedge PCLK); w++; end
    if (!busy) begin check("capture start timeout", 32'd0, 32'd1); return; end
    while (busy && len < maxlen) begin
      if ((len % per == 0) && (len / per < nbits)) bits[len/per] = UART_SOUT;
      len++;
      @(negedge PCLK);
    end
  endtask

  logic [255:0] bits;
  int           len, quiet;

  initial begin
    repeat (3) @(negedge PCLK);
    chk_on = 1'b1;
    // reset state
    check("rst sout",  UART_SOUT, 1); check("rst level", level, 0);
    check("rst empty", empty, 1);     check("rst full", full, 0);
    check("rst rdyn",  TXDRDYn, 0);   check("rst busy", busy, 0);
    check("rst ovf",   overflow, 0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // basic frame 0x55, divisor 3, plus push-to-start latency
    tx_en = 1'b1; divisor = 16'd3;
    push(8'h55);
    check("lat empty t+1", empty, 0);
    check("lat sout t+1", UART_SOUT, 1);
    @(negedge PCLK);
    check("lat sout t+2", UART_SOUT, 0);
    check("lat busy t+2", busy, 1);
    divisor = 16'd7;  // mid-frame change must not affect this frame
    capture(4, 10, 200, bits, len);
    check("f55 bits", bits[9:0], 10'h2AA);
    check("f55 len", len, 40);
    wait_idle();

    // even parity
    divisor = 16'd1; parity_en = 1'b1; parity_odd = 1'b0;
    push(8'h07);
    capture(2, 11, 200, bits, len);
    check("par even bits", bits[10:0], 11'h60E);
    check("par even len", len, 22);
    wait_idle();
    // odd parity
    parity_odd = 1'b1;
    push(8'h07);
    capture(2, 11, 200, bits, len);
    check("par odd bits", bits[10:0], 11'h40E);
    check("par odd len", len, 22);
    wait_idle();
    parity_en = 1'b0; parity_odd = 1'b0;

    // fill, overflow, drain in order
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      @(negedge PCLK);
    end
    wr_en = 1'b0;
    check("fill level", level, 16); check("fill full", full, 1);
    check("fill rdyn", TXDRDYn, 1); check("fill ovf", overflow, 0);
    push(8'hEE);
    check("ovf pulse", overflow, 1); check("ovf level", level, 16);
    @(negedge PCLK);
    check("ovf clear", overflow, 0);
    divisor = 16'd0; tx_en = 1'b1;
    capture(1, 160, 400, bits, len);
    check("drain len", len, 160);
    for (int i = 0; i < 16; i++) begin
      check("drain start", bits[i*10], 0);
      check("drain word", bits[i*10+1 +: 8], 8'h30 + 8'(i));
    end
    wait_idle();

    // back-to-back, two stop bits, divisor 0
    stop2 = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA0; @(negedge PCLK);
    wr_data = 8'h0F; @(negedge PCLK);
    wr_en = 1'b0;
    capture(1, 22, 100, bits, len);
    check("b2b bits", bits[21:0], 22'h30F740);
    check("b2b len", len, 22);
    wait_idle();
    stop2 = 1'b0;

    // reset mid-frame with words queued
    tx_en = 1'b0; divisor = 16'd3;
    push(8'h11); push(8'h22); push(8'h33);
    tx_en = 1'b1;
    repeat (8) @(negedge PCLK);
    check("pre-rst busy", busy, 1);
    PRESET = 1'b1; @(negedge PCLK); PRESET = 1'b0;
    check("mid rst sout", UART_SOUT, 1); check("mid rst level", level, 0);
    check("mid rst empty", empty, 1);    check("mid rst busy", busy, 0);
    quiet = 0;
    repeat (30) begin
      @(negedge PCLK);
      if (UART_SOUT !== 1'b1 || busy !== 1'b0) quiet++;
    end
    check("post rst quiet", quiet, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
